sha256_msg_sched: RTL and testbench

- Upstream neighbour of the SHA-256 round unit. Produces, one per cycle, the message-schedule word W_t and round constant K_t for t = 0..63, feeding the round unit's w (in8) and k (in9) inputs.
- Consumes a 512-bit block as 16 big-endian 32-bit words streamed on in0 (e.g. from a memory unit), then expands W_16..W_63 internally.
- Same run/delay/done control contract as the other Versat functional units.

---
 rtl/sha256_pkg.sv | 44 ++++
 rtl/sha256_k_rom.sv | 13 +
 rtl/sha256_msg_sched.sv | 112 +++++++++++
 tb/tb_sha256_msg_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FIPS 180-4 round constants, the rotate
// primitive, the small-sigma message-expansion functions, and the state
// encoding of the message scheduler. The round unit imports rotr from here.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GEN  = 2'd2
  } sched_state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotate right by a constant amount (0 < n < 32).
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-256 round-constant lookup.
//   idx : round index 0..63
//   k   : K[idx], purely combinational
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  assign k = K_ROM[idx];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler. After a run pulse and delay0 idle cycles it
// performs 64 consecutive steps, emitting W_t, K_t and t for the round unit.
//   clk, rst : clock, synchronous active-high reset
//   run      : start / restart pulse
//   delay0   : idle cycles between run and the first step
//   in0      : message word M_t, consumed in steps 0..15
//   out0     : registered W_t
//   out1     : registered K_t
//   out2     : registered t, zero-extended
//   done     : high when not generating
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  output logic [DATA_W-1:0]  out2,
  output logic               done,
  input  logic [DELAY_W-1:0] delay0
);

  if (DATA_W != 32) begin : g_bad_width
    $error("sha256_msg_sched supports DATA_W == 32 only");
  end

  sched_state_t       state_q, state_d;
  logic [DELAY_W-1:0] delay_q;
  logic [5:0]         t_q;
  // win_q[15] is W[t-1], win_q[0] is W[t-16].
  logic [DATA_W-1:0]  win_q [16];
  logic               step;
  logic [DATA_W-1:0]  w_new;
  logic [DATA_W-1:0]  k_t;

  sha256_k_rom u_k_rom (
    .idx (t_q),
    .k   (k_t)
  );

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_WAIT: begin
        if (delay_q == '0) begin
          step    = 1'b1;
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        step = 1'b1;
        if (t_q == 6'd63) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A run in any state aborts the current work; no step in that cycle.
    if (run) begin
      state_d = ST_WAIT;
      step    = 1'b0;
    end
  end

  always_comb begin
    if (t_q < 6'd16) w_new = in0;
    else             w_new = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the window is reset like any other register because its zero
  // contents are part of the defined reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_q <= '0;
      t_q     <= '0;
      out0    <= '0;
      out1    <= '0;
      out2    <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else if (run) begin
      delay_q <= delay0;
      t_q     <= '0;
    end else begin
      if (state_q == ST_WAIT && delay_q != '0) delay_q <= delay_q - DELAY_W'(1);
      if (step) begin
        out0 <= w_new;
        out1 <= k_t;
        out2 <= {{(DATA_W-6){1'b0}}, t_q};
        t_q  <= t_q + 6'd1;
        for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
        win_q[15] <= w_new;
      end
    end
  end

  assign done = (state_q == ST_IDLE);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: reset, the "abc" block with a
// full SHA-256 compression over the emitted stream, delayed start, restart,
// maximum delay and random blocks against a schedule computed from the
// defining recurrence.
module tb_sha256_msg_sched;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] in0;
  logic [31:0] out0;
  logic [31:0] out1;
  logic [31:0] out2;
  logic        done;
  logic [7:0]  delay0;

  int total = 0;
  int bad   = 0;

  logic [31:0] blk   [16];
  logic [31:0] w_ref [64];
  logic [31:0] obs_w [64];
  logic [31:0] obs_k [64];
  logic [31:0] exp_o0, exp_o1, exp_o2;

  logic [31:0] k_ref [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] iv [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic [31:0] abc_digest [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  sha256_msg_sched #(.DATA_W(32), .DELAY_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .in0    (in0),
    .out0   (out0),
    .out1   (out1),
    .out2   (out2),
    .done   (done),
    .delay0 (delay0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic void compute_ref();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w_ref[t] = blk[t];
      else        w_ref[t] = sig1(w_ref[t-2]) + w_ref[t-7] + sig0(w_ref[t-15]) + w_ref[t-16];
    end
  endfunction

  function automatic void random_block();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    compute_ref();
  endfunction

  // Starts at a negedge: pulses run, idles through the delay, then runs
  // steps 0..stop_at-1, checking every cycle. Returns at the negedge after
  // the last step it checked.
  task automatic drive_block(input logic [7:0] d, input int stop_at, input string tag);
    run    = 1'b1;
    delay0 = d;
    in0    = $urandom;
    @(negedge clk);
    run = 1'b0;
    for (int i = 0; i <= int'(d); i++) begin
      total++;
      if (done !== 1'b0 || out0 !== exp_o0 || out1 !== exp_o1 || out2 !== exp_o2) begin
        bad++;
        $display("FAIL %s wait%0d done=%b out0=%08h out1=%08h out2=%0d want done=0 out0=%08h out1=%08h out2=%0d",
                 tag, i, done, out0, out1, out2, exp_o0, exp_o1, exp_o2);
      end
      if (i < int'(d)) begin
        in0 = $urandom;
        @(negedge clk);
      end
    end
    for (int t = 0; t < stop_at; t++) begin
      in0 = (t < 16) ? blk[t] : $urandom;
      @(negedge clk);
      total++;
      if (out0 !== w_ref[t] || out1 !== k_ref[t] || out2 !== 32'(t) || done !== (t == 63)) begin
        bad++;
        $display("FAIL %s t=%0d out0=%08h out1=%08h out2=%0d done=%b want out0=%08h out1=%08h out2=%0d done=%b",
                 tag, t, out0, out1, out2, done, w_ref[t], k_ref[t], t, (t == 63));
      end
      obs_w[t] = out0;
      obs_k[t] = out1;
      exp_o0 = w_ref[t];
      exp_o1 = k_ref[t];
      exp_o2 = 32'(t);
    end
    in0 = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (out0 !== 0 || out1 !== 0 || out2 !== 0 || done !== 1'b1) begin
      bad++;
      $display("FAIL reset_init out0=%08h out1=%08h out2=%08h done=%b want 0 0 0 1", out0, out1, out2, done);
    end
    rst = 1'b0;
    exp_o0 = '0; exp_o1 = '0; exp_o2 = '0;
    // Reset in the middle of generation, with step 20 pending.
    random_block();
    drive_block(8'd0, 20, "pre_reset");
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (out0 !== 0 || out1 !== 0 || out2 !== 0 || done !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid out0=%08h out1=%08h out2=%08h done=%b want 0 0 0 1", out0, out1, out2, done);
    end
    // Reset and run together: reset wins and the unit stays idle.
    run = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || out2 !== 0) begin
      bad++;
      $display("FAIL reset_vs_run done=%b out2=%0d want done=1 out2=0", done, out2);
    end
    exp_o0 = '0; exp_o1 = '0; exp_o2 = '0;
    random_block();
    drive_block(8'd0, 64, "after_reset");
  endtask

  task automatic test_abc();
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [31:0] hv [8];
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    compute_ref();
    drive_block(8'd0, 64, "abc");
    total++;
    if (obs_w[16] !== 32'h61626380 || obs_w[17] !== 32'h000f0000) begin
      bad++;
      $display("FAIL abc_w16_w17 got %08h %08h want 61626380 000f0000", obs_w[16], obs_w[17]);
    end
    total++;
    if (obs_k[0] !== 32'h428a2f98 || obs_k[63] !== 32'hc67178f2) begin
      bad++;
      $display("FAIL abc_k0_k63 got %08h %08h want 428a2f98 c67178f2", obs_k[0], obs_k[63]);
    end
    // Compress the emitted W/K stream and compare with the known digest.
    a = iv[0]; b = iv[1]; c = iv[2]; d = iv[3];
    e = iv[4]; f = iv[5]; g = iv[6]; h = iv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + obs_k[t] + obs_w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    hv[0] = a + iv[0]; hv[1] = b + iv[1]; hv[2] = c + iv[2]; hv[3] = d + iv[3];
    hv[4] = e + iv[4]; hv[5] = f + iv[5]; hv[6] = g + iv[6]; hv[7] = h + iv[7];
    for (int i = 0; i < 8; i++) begin
      total++;
      if (hv[i] !== abc_digest[i]) begin
        bad++;
        $display("FAIL abc_digest word%0d got %08h want %08h", i, hv[i], abc_digest[i]);
      end
    end
    // Outputs hold the last step while idle.
    repeat (3) @(negedge clk);
    total++;
    if (out0 !== w_ref[63] || out1 !== 32'hc67178f2 || out2 !== 32'd63 || done !== 1'b1) begin
      bad++;
      $display("FAIL abc_hold out0=%08h out1=%08h out2=%0d done=%b want %08h c67178f2 63 1",
               out0, out1, out2, done, w_ref[63]);
    end
  endtask

  task automatic test_delay();
    random_block();
    drive_block(8'd5, 64, "delay5");
    random_block();
    drive_block(8'd255, 64, "delay255");
  endtask

  task automatic test_restart();
    random_block();
    drive_block(8'd1, 30, "restart_a");
    random_block();
    drive_block(8'd2, 64, "restart_b");
    random_block();
    drive_block(8'd0, 5, "restart_c");
    random_block();
    drive_block(8'd0, 64, "restart_d");
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      random_block();
      drive_block(8'($urandom_range(0, 3)), 64, "random");
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    rst    = 1'b1;
    run    = 1'b0;
    in0    = '0;
    delay0 = '0;
    exp_o0 = '0; exp_o1 = '0; exp_o2 = '0;
    @(negedge clk);
    test_reset();
    test_abc();
    test_delay();
    test_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
